// File: rtl/grid_scan_driver.sv
// grid_scan_driver: double-buffered 8x8 row scanner for the life grid.
// Frames are swapped only at frame boundaries so a scan never tears.
module grid_scan_driver #(
    parameter int DWELL = 1024,
    parameter int BLANK = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        on,
    input  logic [63:0] grid,
    input  logic        grid_valid,
    output logic [7:0]  row_sel,
    output logic [7:0]  col_data,
    output logic        frame_done,
    output logic [6:0]  population
);

    localparam int CMAX = (DWELL > BLANK) ? DWELL : BLANK;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
    localparam logic [CW-1:0] DW_LAST = CW'(DWELL - 1);
    localparam logic [CW-1:0] BL_LAST = CW'(BLANK - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BLANK,
        S_DRIVE
    } state_t;

    state_t        state, state_n;
    logic [2:0]    row, row_n;
    logic [CW-1:0] cycle, cycle_n;
    logic [63:0]   shadow, active;
    logic          pending;
    logic          boundary;
    logic [6:0]    ones;

    always_comb begin
        state_n    = state;
        row_n      = row;
        cycle_n    = cycle;
        boundary   = 1'b0;
        frame_done = 1'b0;
        if (!on) begin
            state_n = S_IDLE;
            row_n   = 3'd0;
            cycle_n = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    state_n  = S_BLANK;
                    row_n    = 3'd0;
                    cycle_n  = '0;
                    boundary = 1'b1;
                end
                S_BLANK: begin
                    if (cycle == BL_LAST) begin
                        state_n = S_DRIVE;
                        cycle_n = '0;
                    end else begin
                        cycle_n = cycle + 1'b1;
                    end
                end
                S_DRIVE: begin
                    if (cycle == DW_LAST) begin
                        state_n = S_BLANK;
                        cycle_n = '0;
                        row_n   = row + 3'd1;
                        if (row == 3'd7) begin
                            frame_done = 1'b1;
                            boundary   = 1'b1;
                        end
                    end else begin
                        cycle_n = cycle + 1'b1;
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    always_comb begin
        ones = 7'd0;
        for (int i = 0; i < 64; i++) begin
            ones = ones + 7'(active[i]);
        end
    end

    // Outputs are computed from the next state so row_sel/col_data line up
    // with the state register on every edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            row        <= 3'd0;
            cycle      <= '0;
            shadow     <= '0;
            active     <= '0;
            pending    <= 1'b0;
            row_sel    <= '0;
            col_data   <= '0;
            population <= '0;
        end else begin
            state      <= state_n;
            row        <= row_n;
            cycle      <= cycle_n;
            population <= ones;
            if (boundary && pending) begin
                active <= shadow;
            end
            if (grid_valid) begin
                shadow  <= grid;
                pending <= 1'b1;
            end else if (boundary) begin
                pending <= 1'b0;
            end
            if (state_n == S_DRIVE) begin
                row_sel  <= 8'd1 << row_n;
                col_data <= active[8*row_n +: 8];
            end else begin
                row_sel  <= '0;
                col_data <= '0;
            end
        end
    end

endmodule

// File: tb/tb_grid_scan_driver.sv
// tb_grid_scan_driver: directed and random scan checks against a
// timeline-based reference model (position within frame from elapsed time).
module tb_grid_scan_driver;

    localparam int DW = 4;
    localparam int BL = 1;
    localparam int RP = BL + DW;
    localparam int P  = 8 * RP;

    logic        clk = 1'b0;
    logic        reset;
    logic        on = 1'b0;
    logic [63:0] grid = '0;
    logic        grid_valid = 1'b0;
    logic [7:0]  row_sel;
    logic [7:0]  col_data;
    logic        frame_done;
    logic [6:0]  population;

    int errors = 0;
    int checks = 0;

    bit          run = 0;
    int          t = 0;
    logic [63:0] m_shadow = '0;
    logic [63:0] m_active = '0;
    bit          m_pending = 0;
    logic [6:0]  m_pop = '0;

    grid_scan_driver #(.DWELL(DW), .BLANK(BL)) dut (
        .clk        (clk),
        .reset      (reset),
        .on         (on),
        .grid       (grid),
        .grid_valid (grid_valid),
        .row_sel    (row_sel),
        .col_data   (col_data),
        .frame_done (frame_done),
        .population (population)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic o, input logic gv, input logic [63:0] g);
        bit fd;
        bit bnd;
        int pos;
        int row;
        logic [7:0] ers;
        logic [7:0] ecd;
        @(negedge clk);
        on = o;
        grid_valid = gv;
        grid = g;
        #1;
        pos = t % P;
        fd  = run && o && (pos == P - 1);
        bnd = o && (!run || pos == P - 1);
        chk("frame_done", {63'd0, frame_done}, {63'd0, fd});
        @(posedge clk);
        m_pop = 7'($countones(m_active));
        if (bnd && m_pending) begin
            m_active  = m_shadow;
            m_pending = 0;
        end
        if (gv) begin
            m_shadow  = g;
            m_pending = 1;
        end
        if (!o) run = 0;
        else if (!run) begin
            run = 1;
            t = 0;
        end else t++;
        #1;
        ers = '0;
        ecd = '0;
        if (run) begin
            pos = t % P;
            row = pos / RP;
            if ((pos % RP) >= BL) begin
                ers = 8'(1 << row);
                ecd = m_active[8*row +: 8];
            end
        end
        chk("row_sel", {56'd0, row_sel}, {56'd0, ers});
        chk("col_data", {56'd0, col_data}, {56'd0, ecd});
        chk("population", {57'd0, population}, {57'd0, m_pop});
    endtask

    task automatic idle_run(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, '0);
    endtask

    task automatic seek(input int target);
        bit found = 0;
        for (int i = 0; i < 2 * P && !found; i++) begin
            if (run && (t % P) == target) found = 1;
            else cyc(1'b1, 1'b0, '0);
        end
        chk("seek", {63'd0, found}, 64'd1);
    endtask

    task automatic reset_check(input string tag);
        chk({tag, "_row_sel"}, {56'd0, row_sel}, 64'd0);
        chk({tag, "_col_data"}, {56'd0, col_data}, 64'd0);
        chk({tag, "_frame_done"}, {63'd0, frame_done}, 64'd0);
        chk({tag, "_population"}, {57'd0, population}, 64'd0);
    endtask

    initial begin
        reset = 1'b1;
        #2 reset = 1'b0;
        #1 reset_check("reset");
        run = 0;
        @(negedge clk);
        reset = 1'b1;

        cyc(1'b0, 1'b1, 64'h0000_0000_0000_00FF);
        cyc(1'b1, 1'b0, '0);
        cyc(1'b1, 1'b0, '0);
        chk("row0_sel", {56'd0, row_sel}, 64'h01);
        chk("row0_col", {56'd0, col_data}, 64'hFF);
        chk("pop8", {57'd0, population}, 64'd8);

        idle_run(2 * P);

        seek(10);
        cyc(1'b1, 1'b1, '1);
        idle_run(2 * P);
        chk("pop64", {57'd0, population}, 64'd64);

        seek(P - 1);
        cyc(1'b1, 1'b1, 64'hA5A5_0F0F_3C3C_8001);
        idle_run(2 * P + 3);

        seek(3 * RP + BL + 1);
        cyc(1'b0, 1'b0, '0);
        chk("off_row_sel", {56'd0, row_sel}, 64'd0);
        cyc(1'b1, 1'b0, '0);
        cyc(1'b1, 1'b0, '0);
        chk("restart_row0", {56'd0, row_sel}, 64'h01);
        idle_run(P);

        seek(5 * RP + BL + 1);
        @(negedge clk);
        #2 reset = 1'b0;
        #1 reset_check("midreset");
        run = 0;
        m_shadow = '0;
        m_active = '0;
        m_pending = 0;
        m_pop = '0;
        on = 1'b0;
        grid_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 800; i++) begin
            cyc(($urandom_range(0, 49) != 0),
                ($urandom_range(0, 15) == 0),
                {$urandom, $urandom});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
